// File: rtl/fetch_queue.sv
// Instruction fetch queue: decouples fetch from decode. Each entry carries a
// sequence tag. Flush discards all entries and counts how many were dropped.
module fetch_queue #(
  parameter int DBITS    = 32,
  parameter int INSTBITS = 32,
  parameter int DEPTH    = 4,
  parameter int SEQBITS  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [DBITS-1:0]           enq_pc,
  input  logic [INSTBITS-1:0]        enq_inst,
  input  logic                       enq_pred_taken,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [DBITS-1:0]           deq_pc,
  output logic [INSTBITS-1:0]        deq_inst,
  output logic                       deq_pred_taken,
  output logic [SEQBITS-1:0]         deq_seq,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                flush_drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [SEQBITS-1:0] seq_q, seq_d;
  logic [15:0]        drop_q, drop_d;
  logic [16:0]        drop_sum;
  logic               do_enq, do_deq;

  logic [DBITS-1:0]    pc_mem_q   [DEPTH];
  logic [INSTBITS-1:0] inst_mem_q [DEPTH];
  logic                pt_mem_q   [DEPTH];
  logic [SEQBITS-1:0]  seq_mem_q  [DEPTH];

  // Handshake flags depend only on registered occupancy.
  assign enq_ready = (count_q < CW'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign do_enq    = enq_valid && enq_ready && !flush;
  assign do_deq    = deq_valid && deq_ready && !flush;
  assign drop_sum  = {1'b0, drop_q} + 17'(count_q);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end else begin
      if (do_enq) begin
        tail_d = tail_q + PW'(1);
        seq_d  = seq_q + SEQBITS'(1);
      end
      if (do_deq) head_d = head_q + PW'(1);
      count_d = count_q + CW'(do_enq) - CW'(do_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      pc_mem_q[tail_q]   <= enq_pc;
      inst_mem_q[tail_q] <= enq_inst;
      pt_mem_q[tail_q]   <= enq_pred_taken;
      seq_mem_q[tail_q]  <= seq_q;
    end
  end

  assign deq_pc         = pc_mem_q[head_q];
  assign deq_inst       = inst_mem_q[head_q];
  assign deq_pred_taken = pt_mem_q[head_q];
  assign deq_seq        = seq_mem_q[head_q];
  assign count          = count_q;
  assign flush_drop_cnt = drop_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked
// against a queue-based model of occupancy, ordering, tags and drop count.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, enq_valid, enq_pred_taken, deq_ready, flush;
  logic [31:0] enq_pc, enq_inst;
  logic        enq_ready, deq_valid, deq_pred_taken;
  logic [31:0] deq_pc, deq_inst;
  logic [7:0]  deq_seq;
  logic [2:0]  count;
  logic [15:0] flush_drop_cnt;

  fetch_queue dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_inst(enq_inst), .enq_pred_taken(enq_pred_taken),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_inst(deq_inst), .deq_pred_taken(deq_pred_taken), .deq_seq(deq_seq),
    .flush(flush), .count(count), .flush_drop_cnt(flush_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pt;
    int          seq;
  } entry_t;

  entry_t m_q[$];
  int     m_seq  = 0;
  int     m_drop = 0;
  int     n_chk  = 0;
  int     n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 64'(count), 64'(m_q.size()));
    chk("enq_ready", 64'(enq_ready), 64'(m_q.size() < DEPTH));
    chk("deq_valid", 64'(deq_valid), 64'(m_q.size() != 0));
    chk("drop_cnt", 64'(flush_drop_cnt), 64'(m_drop));
    if (m_q.size() != 0) begin
      chk("deq_pc", 64'(deq_pc), 64'(m_q[0].pc));
      chk("deq_inst", 64'(deq_inst), 64'(m_q[0].inst));
      chk("deq_pt", 64'(deq_pred_taken), 64'(m_q[0].pt));
      chk("deq_seq", 64'(deq_seq), 64'(m_q[0].seq));
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, then check.
  task automatic step(input logic ev, input logic dr, input logic fl,
                      input logic [31:0] pc, input logic rst);
    bit     enq_ok, deq_ok;
    entry_t e;
    @(negedge clk);
    reset = rst; enq_valid = ev; deq_ready = dr; flush = fl;
    enq_pc = pc; enq_inst = $urandom; enq_pred_taken = 1'($urandom);
    e.pc = pc; e.inst = enq_inst; e.pt = enq_pred_taken; e.seq = m_seq;
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_seq = 0; m_drop = 0;
    end else if (fl) begin
      m_drop = (m_drop + m_q.size() > 65535) ? 65535 : m_drop + m_q.size();
      m_q.delete();
    end else begin
      deq_ok = dr && (m_q.size() > 0);
      enq_ok = ev && (m_q.size() < DEPTH);
      if (deq_ok) void'(m_q.pop_front());
      if (enq_ok) begin
        m_q.push_back(e);
        m_seq = (m_seq + 1) % 256;
      end
    end
    #1 check_all();
  endtask

  initial begin
    int old_seq;
    reset = 1'b1; enq_valid = 0; deq_ready = 0; flush = 0;
    enq_pc = 0; enq_inst = 0; enq_pred_taken = 0;

    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 32'h55, 1);  // reset overrides everything
    chk("rst_enq_ready", 64'(enq_ready), 64'(1));

    // Fill to full
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h100 + 32'(4*i), 0);
    chk("fill_pc", 64'(deq_pc), 64'h100);
    chk("fill_seq", 64'(deq_seq), 64'h0);
    chk("fill_ready", 64'(enq_ready), 64'h0);

    // Full with simultaneous enq/deq: dequeue only
    step(1, 1, 0, 32'h200, 0);
    chk("full_sim_cnt", 64'(count), 64'd3);
    chk("full_sim_pc", 64'(deq_pc), 64'h104);

    // Drain to one entry then stream for 10 cycles
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h300 + 32'(4*i), 0);
    chk("stream_cnt", 64'(count), 64'd1);

    // Bring to 3 entries then flush with enq_valid high
    step(1, 0, 0, 32'h400, 0);
    step(1, 0, 0, 32'h404, 0);
    old_seq = m_seq;
    step(1, 1, 1, 32'h408, 0);
    chk("flush_cnt", 64'(count), 64'd0);
    chk("flush_drop", 64'(flush_drop_cnt), 64'd3);
    step(1, 0, 0, 32'h500, 0);
    chk("post_flush_seq", 64'(deq_seq), 64'(old_seq));

    // Seq wrap: 256 enqueue/dequeue pairs
    for (int i = 0; i < 256; i++) step(1, 1, 0, 32'h1000 + 32'(4*i), 0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0), $urandom, 0);

    // Reset mid-operation with two entries present
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 32'h700, 0);
    step(1, 0, 0, 32'h704, 0);
    chk("pre_rst_cnt", 64'(count), 64'd2);
    step(1, 1, 0, 32'h708, 1);
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_drop", 64'(flush_drop_cnt), 64'd0);
    step(1, 0, 0, 32'h800, 0);
    chk("rst_seq", 64'(deq_seq), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
